// File: rtl/seven_seg_scanner.sv
// Two-digit seven-segment scan driver with frame-synchronous double buffering.
// Define SEVENSEG_GHOST_GAP_EN to insert a dark slot between digit slots.
module seven_seg_scanner #(
  parameter int PRESCALE = 50000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] SevenSegDig1,
  input  logic [7:0] SevenSegDig2,
  input  logic       Load,
  input  logic       Blank,
  output logic [7:0] SegOut,
  output logic [1:0] DigEn,
  output logic       FrameStart,
  output logic       Pending
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    SHOW1 = 2'd0,
    GAP1  = 2'd1,
    SHOW2 = 2'd2,
    GAP2  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_disp1;
  logic [7:0]      r_disp2;
  logic [7:0]      r_pend1;
  logic [7:0]      r_pend2;
  logic            r_pending;
  logic            r_fs;
  logic            w_tick;
  logic            w_commit;

  assign w_tick = (r_cnt == LAST);

  always_comb begin
    w_state_nx = r_state;
    if (w_tick) begin
      unique case (r_state)
`ifdef SEVENSEG_GHOST_GAP_EN
        SHOW1:   w_state_nx = GAP1;
        GAP1:    w_state_nx = SHOW2;
        SHOW2:   w_state_nx = GAP2;
        GAP2:    w_state_nx = SHOW1;
`else
        SHOW1:   w_state_nx = SHOW2;
        SHOW2:   w_state_nx = SHOW1;
        GAP1:    w_state_nx = SHOW1;
        GAP2:    w_state_nx = SHOW1;
`endif
        default: w_state_nx = SHOW1;
      endcase
    end
  end

  // Commit happens on the edge that moves the scan into SHOW1.
  assign w_commit = w_tick && (w_state_nx == SHOW1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= SHOW1;
      r_cnt   <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
      r_fs    <= w_commit;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_disp1   <= 8'h00;
      r_disp2   <= 8'h00;
      r_pend1   <= 8'h00;
      r_pend2   <= 8'h00;
      r_pending <= 1'b0;
    end else if (w_commit) begin
      r_pending <= 1'b0;
      if (Load) begin
        r_disp1 <= SevenSegDig1;
        r_disp2 <= SevenSegDig2;
      end else if (r_pending) begin
        r_disp1 <= r_pend1;
        r_disp2 <= r_pend2;
      end
    end else if (Load) begin
      r_pend1   <= SevenSegDig1;
      r_pend2   <= SevenSegDig2;
      r_pending <= 1'b1;
    end
  end

  always_comb begin
    SegOut = 8'h00;
    DigEn  = 2'b00;
    if (!Blank) begin
      unique case (r_state)
        SHOW1: begin
          SegOut = r_disp1;
          DigEn  = 2'b01;
        end
        SHOW2: begin
          SegOut = r_disp2;
          DigEn  = 2'b10;
        end
        default: begin
          SegOut = 8'h00;
          DigEn  = 2'b00;
        end
      endcase
    end
  end

  assign FrameStart = r_fs;
  assign Pending    = r_pending;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at PRESCALE=4.
// Expectations follow the build: 4-slot frame with SEVENSEG_GHOST_GAP_EN, else 2.
module tb_seven_seg_scanner;

  logic       clk;
  logic       rst_n;
  logic [7:0] d1;
  logic [7:0] d2;
  logic       ld;
  logic       bl;
  logic [7:0] seg;
  logic [1:0] dig;
  logic       fs;
  logic       pend;

  int cmp_cnt;
  int err_cnt;

`ifdef SEVENSEG_GHOST_GAP_EN
  localparam int FRAME = 16;
`else
  localparam int FRAME = 8;
`endif

  typedef struct {
    int         cyc;
    logic       ld;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       bl;
    logic [7:0] seg;
    logic [1:0] dig;
    logic       fs;
    logic       pend;
  } vec_t;

  vec_t tbl[$];

  seven_seg_scanner #(.PRESCALE(4)) dut (
    .Clk          (clk),
    .Rst_n        (rst_n),
    .SevenSegDig1 (d1),
    .SevenSegDig2 (d2),
    .Load         (ld),
    .Blank        (bl),
    .SegOut       (seg),
    .DigEn        (dig),
    .FrameStart   (fs),
    .Pending      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int c, logic l, logic [7:0] a,
                              logic [7:0] b, logic k, logic [7:0] s,
                              logic [1:0] g, logic f, logic p);
    vec_t v;
    v.cyc = c; v.ld = l; v.d1 = a; v.d2 = b; v.bl = k;
    v.seg = s; v.dig = g; v.fs = f; v.pend = p;
    return v;
  endfunction

  function automatic logic [1:0] exp_dig(int n, logic b);
    int idx;
    if (b) return 2'b00;
`ifdef SEVENSEG_GHOST_GAP_EN
    idx = (n / 4) % 4;
`else
    idx = ((n / 4) % 2) * 2;
`endif
    if (idx == 0) return 2'b01;
    if (idx == 2) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    int idx;
    int last;
    cmp_cnt = 0;
    err_cnt = 0;
`ifdef SEVENSEG_GHOST_GAP_EN
    tbl.push_back(mk( 18,1,8'h79,8'h77,0, 8'h00,2'b01,0,1));
    tbl.push_back(mk( 25,0,8'h00,8'h00,0, 8'h00,2'b10,0,1));
    tbl.push_back(mk( 32,0,8'h00,8'h00,0, 8'h79,2'b01,1,0));
    tbl.push_back(mk( 35,0,8'h00,8'h00,0, 8'h79,2'b01,0,0));
    tbl.push_back(mk( 36,0,8'h00,8'h00,0, 8'h00,2'b00,0,0));
    tbl.push_back(mk( 37,1,8'h06,8'h5B,0, 8'h00,2'b00,0,1));
    tbl.push_back(mk( 40,0,8'h00,8'h00,0, 8'h77,2'b10,0,1));
    tbl.push_back(mk( 41,1,8'h4F,8'h66,0, 8'h77,2'b10,0,1));
    tbl.push_back(mk( 48,0,8'h00,8'h00,0, 8'h4F,2'b01,1,0));
    tbl.push_back(mk( 56,0,8'h00,8'h00,0, 8'h66,2'b10,0,0));
    tbl.push_back(mk( 64,1,8'h3F,8'h3F,0, 8'h3F,2'b01,1,0));
    tbl.push_back(mk( 66,1,8'h79,8'h77,0, 8'h3F,2'b01,0,1));
    tbl.push_back(mk( 72,0,8'h00,8'h00,0, 8'h3F,2'b10,0,1));
    tbl.push_back(mk( 80,0,8'h00,8'h00,0, 8'h79,2'b01,1,0));
    tbl.push_back(mk( 81,0,8'h00,8'h00,1, 8'h00,2'b00,0,0));
    tbl.push_back(mk( 88,0,8'h00,8'h00,1, 8'h00,2'b00,0,0));
    tbl.push_back(mk( 96,0,8'h00,8'h00,1, 8'h00,2'b00,1,0));
    tbl.push_back(mk(104,0,8'h00,8'h00,1, 8'h00,2'b00,0,0));
    tbl.push_back(mk(106,0,8'h00,8'h00,0, 8'h77,2'b10,0,0));
    tbl.push_back(mk(113,1,8'h5B,8'h4F,0, 8'h79,2'b01,0,1));
    tbl.push_back(mk(121,0,8'h00,8'h00,0, 8'h77,2'b10,0,1));
`else
    tbl.push_back(mk(10,1,8'h79,8'h77,0, 8'h00,2'b01,0,1));
    tbl.push_back(mk(13,0,8'h00,8'h00,0, 8'h00,2'b10,0,1));
    tbl.push_back(mk(16,0,8'h00,8'h00,0, 8'h79,2'b01,1,0));
    tbl.push_back(mk(19,0,8'h00,8'h00,0, 8'h79,2'b01,0,0));
    tbl.push_back(mk(20,0,8'h00,8'h00,0, 8'h77,2'b10,0,0));
    tbl.push_back(mk(21,1,8'h06,8'h5B,0, 8'h77,2'b10,0,1));
    tbl.push_back(mk(22,1,8'h4F,8'h66,0, 8'h77,2'b10,0,1));
    tbl.push_back(mk(24,0,8'h00,8'h00,0, 8'h4F,2'b01,1,0));
    tbl.push_back(mk(28,0,8'h00,8'h00,0, 8'h66,2'b10,0,0));
    tbl.push_back(mk(32,1,8'h3F,8'h3F,0, 8'h3F,2'b01,1,0));
    tbl.push_back(mk(34,1,8'h79,8'h77,0, 8'h3F,2'b01,0,1));
    tbl.push_back(mk(36,0,8'h00,8'h00,0, 8'h3F,2'b10,0,1));
    tbl.push_back(mk(40,0,8'h00,8'h00,0, 8'h79,2'b01,1,0));
    tbl.push_back(mk(41,0,8'h00,8'h00,1, 8'h00,2'b00,0,0));
    tbl.push_back(mk(44,0,8'h00,8'h00,1, 8'h00,2'b00,0,0));
    tbl.push_back(mk(48,0,8'h00,8'h00,1, 8'h00,2'b00,1,0));
    tbl.push_back(mk(52,0,8'h00,8'h00,1, 8'h00,2'b00,0,0));
    tbl.push_back(mk(54,0,8'h00,8'h00,0, 8'h77,2'b10,0,0));
    tbl.push_back(mk(57,1,8'h5B,8'h4F,0, 8'h79,2'b01,0,1));
    tbl.push_back(mk(61,0,8'h00,8'h00,0, 8'h77,2'b10,0,1));
`endif

    rst_n = 1'b0; ld = 1'b0; bl = 1'b0; d1 = 8'h00; d2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst seg", seg, 8'h00);
    chk("rst dig", {6'd0, dig}, 8'h01);
    chk("rst fs", {7'd0, fs}, 8'h00);
    chk("rst pend", {7'd0, pend}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    idx  = 0;
    last = tbl[tbl.size()-1].cyc;
    for (int n = 1; n <= last; n++) begin
      ld = 1'b0;
      if (idx < tbl.size() && tbl[idx].cyc == n) begin
        ld = tbl[idx].ld;
        d1 = tbl[idx].d1;
        d2 = tbl[idx].d2;
        bl = tbl[idx].bl;
      end
      @(posedge clk);
      #1;
      chk($sformatf("c%0d dig", n), {6'd0, dig}, {6'd0, exp_dig(n, bl)});
      chk($sformatf("c%0d fs", n), {7'd0, fs},
          {7'd0, (n % FRAME == 0) ? 1'b1 : 1'b0});
      if (idx < tbl.size() && tbl[idx].cyc == n) begin
        chk($sformatf("v%0d seg", n), seg, tbl[idx].seg);
        chk($sformatf("v%0d pend", n), {7'd0, pend}, {7'd0, tbl[idx].pend});
        idx++;
      end
    end
    ld = 1'b0;

    // Asynchronous reset mid-SHOW2 with data pending.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst seg", seg, 8'h00);
    chk("arst dig", {6'd0, dig}, 8'h01);
    chk("arst pend", {7'd0, pend}, 8'h00);
    chk("arst fs", {7'd0, fs}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME) @(posedge clk);
    #1;
    chk("post fs", {7'd0, fs}, 8'h01);
    chk("post seg", seg, 8'h00);
    chk("post dig", {6'd0, dig}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
